// File: rtl/add_round_key_pipe_if.sv
// Operation and key-write bus for add_round_key_pipe.
// The master side is the upstream datapath plus the result consumer.
// The slave side is the round-key adder itself.
interface add_round_key_pipe_if #(
  parameter int regSize  = 32,
  parameter int vecSize  = 4,
  parameter int NUM_KEYS = 11
);
  localparam int KIDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int COL_W  = (vecSize > 1) ? $clog2(vecSize) : 1;

  logic                              key_wr_en;
  logic [KIDX_W-1:0]                 key_wr_idx;
  logic [COL_W-1:0]                  key_wr_col;
  logic [regSize-1:0]                key_wr_data;

  logic                              in_valid;
  logic                              in_ready;
  logic [vecSize-1:0][regSize-1:0]   in_state;
  logic [KIDX_W-1:0]                 in_key_idx;
  logic [vecSize-1:0]                in_lane_mask;

  logic                              out_valid;
  logic                              out_ready;
  logic [vecSize-1:0][regSize-1:0]   out_state;
  logic                              out_err;

  modport master (
    output key_wr_en, key_wr_idx, key_wr_col, key_wr_data,
    output in_valid, in_state, in_key_idx, in_lane_mask, out_ready,
    input  in_ready, out_valid, out_state, out_err
  );

  modport slave (
    input  key_wr_en, key_wr_idx, key_wr_col, key_wr_data,
    input  in_valid, in_state, in_key_idx, in_lane_mask, out_ready,
    output in_ready, out_valid, out_state, out_err
  );
endinterface

// File: rtl/add_round_key_pipe.sv
// Two-stage masked AddRoundKey with an on-chip round-key bank.
// Stage 1 snapshots the operand and the whole selected key, so key writes
// landing after acceptance never disturb an in-flight op. Stage 2 holds
// the result under backpressure.
module add_round_key_pipe #(
  parameter int regSize  = 32,
  parameter int vecSize  = 4,
  parameter int NUM_KEYS = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  add_round_key_pipe_if.slave  bus
);
  localparam int KIDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  typedef logic [vecSize-1:0][regSize-1:0] vec_t;

  logic [NUM_KEYS-1:0][vecSize-1:0][regSize-1:0] key_mem;

  logic               wr_ok;
  logic               rd_err;
  vec_t               rd_key;
  logic               s1_load;
  logic               s2_adv;

  logic               s1_valid;
  vec_t               s1_state;
  vec_t               s1_key;
  logic [vecSize-1:0] s1_mask;
  logic               s1_err;
  vec_t               s1_result;

  logic               s2_valid;
  vec_t               s2_state;
  logic               s2_err;

  assign wr_ok  = bus.key_wr_en
                  && (int'(bus.key_wr_idx) < NUM_KEYS)
                  && (int'(bus.key_wr_col) < vecSize);
  assign rd_err = int'(bus.in_key_idx) >= NUM_KEYS;
  // Out-of-range ops carry a zero key so the index never reaches the bank.
  assign rd_key = rd_err ? '0 : key_mem[bus.in_key_idx];

  // Stage 2 can take a new op when it is empty or draining this cycle.
  assign s2_adv       = ~s2_valid | bus.out_ready;
  assign bus.in_ready = rst_n & (~s1_valid | s2_adv);
  assign s1_load      = bus.in_valid & bus.in_ready;

  assign bus.out_valid = s2_valid;
  assign bus.out_state = s2_state;
  assign bus.out_err   = s2_err;

  // Key bank: one column per cycle, out-of-range writes dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_mem <= '0;
    end else if (wr_ok) begin
      key_mem[bus.key_wr_idx][bus.key_wr_col] <= bus.key_wr_data;
    end
  end

  // Stage 1: capture operand and key snapshot (pre-write key contents).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_state <= '0;
      s1_key   <= '0;
      s1_mask  <= '0;
      s1_err   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_state <= bus.in_state;
      s1_key   <= rd_key;
      s1_mask  <= bus.in_lane_mask;
      s1_err   <= rd_err;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Per-column masked XOR; error ops pass the state through untouched.
  always_comb begin
    s1_result = s1_state;
    for (int c = 0; c < vecSize; c++) begin
      if (s1_mask[c] && !s1_err) begin
        s1_result[c] = s1_state[c] ^ s1_key[c];
      end
    end
  end

  // Stage 2: result register, frozen while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_state <= '0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_state <= s1_result;
        s2_err   <= s1_err;
      end
    end
  end
endmodule

// File: tb/tb_add_round_key_pipe.sv
// Scoreboard bench for add_round_key_pipe: driver pushes expected results
// from a behavioural key-bank model, monitor pops on each output transfer.
module tb_add_round_key_pipe;
  localparam int RS = 32;
  localparam int VS = 4;
  localparam int NK = 11;
  localparam int KW = 4;

  typedef logic [VS-1:0][RS-1:0] vec_t;
  typedef struct packed { vec_t state; logic err; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_round_key_pipe_if #(.regSize(RS), .vecSize(VS), .NUM_KEYS(NK)) bus ();

  add_round_key_pipe #(.regSize(RS), .vecSize(VS), .NUM_KEYS(NK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t          sb_q[$];
  logic [RS-1:0] mk [NK][VS];
  int            n_checks = 0;
  int            n_fail = 0;
  int            n_out = 0;
  int            cyc = 0;
  logic          accepted = 1'b0;
  vec_t          last_out;
  logic          last_err;
  logic          held = 1'b0;
  vec_t          held_state;
  logic          held_err;
  exp_t          mon_e;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: each selected column XORed with the stored key column.
  function automatic exp_t model(vec_t s, int idx, logic [VS-1:0] m);
    exp_t e;
    e.state = s;
    e.err   = 1'b0;
    if (idx >= NK) e.err = 1'b1;
    else for (int c = 0; c < VS; c++) if (m[c]) e.state[c] = s[c] ^ mk[idx][c];
    return e;
  endfunction

  // One clock: record accept/key write as seen just before the edge.
  task automatic tick();
    @(negedge clk);
    accepted = 1'b0;
    if (!rst_n) begin
      sb_q.delete();
      for (int k = 0; k < NK; k++) for (int c = 0; c < VS; c++) mk[k][c] = '0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(model(bus.in_state, int'(bus.in_key_idx), bus.in_lane_mask));
        accepted = 1'b1;
      end
      if (bus.key_wr_en && int'(bus.key_wr_idx) < NK)
        mk[bus.key_wr_idx][bus.key_wr_col] = bus.key_wr_data;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_op(vec_t s, logic [KW-1:0] idx, logic [VS-1:0] m);
    int t = 0;
    bus.in_state = s; bus.in_key_idx = idx; bus.in_lane_mask = m; bus.in_valid = 1'b1;
    do begin tick(); t++; end while (!accepted && t < 100);
    if (!accepted) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wr_key(int k, int c, logic [RS-1:0] d);
    bus.key_wr_en = 1'b1; bus.key_wr_idx = KW'(k); bus.key_wr_col = 2'(c); bus.key_wr_data = d;
    tick();
    bus.key_wr_en = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    bus.out_ready = 1'b1;
    while (sb_q.size() > 0 && t < 50) begin tick(); t++; end
    check("drain_empty", sb_q.size(), 0);
  endtask

  function automatic vec_t rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: pop and compare on every output transfer, check hold stability.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !bus.out_valid) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_state", bus.out_state, held_state);
          check("hold_err", bus.out_err, held_err);
        end
        if (bus.out_ready) begin
          held = 1'b0;
          if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_output: got %h expected no output", bus.out_state);
          end else begin
            mon_e = sb_q.pop_front();
            check("out_state", bus.out_state, mon_e.state);
            check("out_err", bus.out_err, mon_e.err);
          end
          n_out++;
          last_out = bus.out_state;
          last_err = bus.out_err;
        end else begin
          held = 1'b1;
          held_state = bus.out_state;
          held_err = bus.out_err;
        end
      end
    end
  end

  initial begin
    vec_t s, s2;
    int start, n0, acc;
    bus.key_wr_en = 1'b0; bus.key_wr_idx = '0; bus.key_wr_col = '0; bus.key_wr_data = '0;
    bus.in_valid = 1'b0; bus.in_state = '0; bus.in_key_idx = '0; bus.in_lane_mask = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_state", bus.out_state, '0);
    check("rst_out_err", bus.out_err, 1'b0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // Basic known-answer vector
    for (int c = 0; c < VS; c++) wr_key(0, c, 32'h62636363);
    send_op({32'h591ceea1, 32'hc28636d1, 32'hcaddaf02, 32'h4a27dca2}, 0, 4'hF);
    check("latency_not_early", bus.out_valid, 1'b0);
    drain();
    check("basic_state", last_out, {32'h3b7f8dc2, 32'ha0e555b2, 32'ha8becc61, 32'h2844bfc1});
    check("basic_err", last_err, 1'b0);

    // Distinct keys in every slot, back-to-back stream with alternating masks
    for (int k = 0; k < NK; k++) for (int c = 0; c < VS; c++) wr_key(k, c, (k << 24) | c);
    start = cyc;
    for (int k = 0; k < NK; k++) send_op(rnd_vec(), KW'(k), (k % 2) ? 4'b0101 : 4'b1010);
    check("throughput_cycles", cyc - start, NK);
    drain();

    // Backpressure: 5 stalled cycles, 3 ops
    n0 = n_out;
    bus.out_ready = 1'b0;
    send_op(rnd_vec(), 4'd2, 4'hF);
    send_op(rnd_vec(), 4'd5, 4'b0011);
    s = rnd_vec();
    bus.in_state = s; bus.in_key_idx = 4'd7; bus.in_lane_mask = 4'b1100; bus.in_valid = 1'b1;
    #1;
    check("bp_in_ready_low", bus.in_ready, 1'b0);
    acc = 0;
    repeat (3) begin tick(); if (accepted) acc++; end
    check("bp_no_accept", acc, 0);
    bus.out_ready = 1'b1;
    send_op(s, 4'd7, 4'b1100);
    drain();
    check("bp_result_count", n_out - n0, 3);

    // Same-edge write hazard on slot 3
    s = rnd_vec(); s2 = rnd_vec();
    bus.key_wr_en = 1'b1; bus.key_wr_idx = 4'd3; bus.key_wr_col = 2'd0; bus.key_wr_data = 32'hFFFFFFFF;
    send_op(s, 4'd3, 4'hF);
    bus.key_wr_en = 1'b0;
    send_op(s2, 4'd3, 4'hF);
    drain();
    check("hazard_new_key_col0", last_out[0], s2[0] ^ 32'hFFFFFFFF);

    // Error index and ignored out-of-range writes
    wr_key(11, 0, 32'hDEADBEEF);
    wr_key(15, 3, 32'hCAFEF00D);
    send_op({4{32'h12345678}}, 4'd11, 4'hF);
    drain();
    check("err_state", last_out, {4{32'h12345678}});
    check("err_flag", last_err, 1'b1);
    for (int k = 0; k < NK; k++) send_op('0, KW'(k), 4'hF);
    drain();

    // Randomised traffic with random stalls, key writes and bad indices
    for (int i = 0; i < 400; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.key_wr_en = ($urandom_range(0, 3) == 0);
      bus.key_wr_idx = KW'($urandom_range(0, 15));
      bus.key_wr_col = 2'($urandom_range(0, 3));
      bus.key_wr_data = $urandom;
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_state = rnd_vec();
      bus.in_key_idx = KW'($urandom_range(0, 12));
      bus.in_lane_mask = 4'($urandom_range(0, 15));
      tick();
    end
    bus.in_valid = 1'b0; bus.key_wr_en = 1'b0;
    drain();

    // Reset with two ops in flight
    bus.out_ready = 1'b0;
    send_op(rnd_vec(), 4'd1, 4'hF);
    send_op(rnd_vec(), 4'd2, 4'hF);
    rst_n = 1'b0;
    tick();
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    n0 = n_out;
    repeat (5) tick();
    check("midrst_no_output", n_out - n0, 0);
    s = rnd_vec();
    send_op(s, 4'd0, 4'hF);
    drain();
    check("post_rst_key_zero", last_out, s);

    check("final_queue_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
